// File: rtl/tdc_decoder_acc_pkg.sv
// Shared widths, sample payload and helpers for the TDC decoder/accumulator.
package tdc_decoder_acc_pkg;

  localparam int unsigned CNT_W   = 7;
  localparam int unsigned NPH     = 16;
  localparam int unsigned FRAC_W  = $clog2(2 * NPH);
  localparam int unsigned WORD_W  = CNT_W + FRAC_W;
  localparam int unsigned AVG_MAX = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned WIN_W   = AVG_MAX;
  localparam int unsigned ACC_W   = WORD_W + AVG_MAX;

  // One captured TDC sample: coarse count plus thermometer.
  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [NPH-1:0]   ph;
  } tdc_sample_t;

  // Averaging exponent limited to the largest supported window.
  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] sel);
    if (32'(sel) > AVG_MAX) return SEL_W'(AVG_MAX);
    return sel;
  endfunction

endpackage

// File: rtl/tdc_decoder_acc_therm_decode.sv
// Cyclic thermometer decoder: majority bubble filter, edge index and bubble flag.
module tdc_decoder_acc_therm_decode #(
  parameter int unsigned NPH   = 16,
  parameter int unsigned IDX_W = $clog2(2 * NPH)
) (
  input  logic [NPH-1:0]   ph,
  output logic             f0,
  output logic [IDX_W-1:0] idx,
  output logic             bub
);

  logic [NPH-1:0] filt;

  // Three-tap majority over cyclic neighbours removes isolated bubbles.
  always_comb begin
    filt = '0;
    for (int i = 0; i < NPH; i++) begin
      filt[i] = (ph[(i + NPH - 1) % NPH] & ph[i])
              | (ph[i] & ph[(i + 1) % NPH])
              | (ph[(i + NPH - 1) % NPH] & ph[(i + 1) % NPH]);
    end
  end

  // Edge scan; later (higher) positions override, no-edge falls back on filt[0].
  always_comb begin
    idx = filt[0] ? IDX_W'(NPH - 1) : IDX_W'(2 * NPH - 1);
    for (int j = 1; j < NPH; j++) begin
      if (filt[j-1] && !filt[j]) begin
        idx = IDX_W'(j - 1);
      end else if (!filt[j-1] && filt[j]) begin
        idx = IDX_W'(j - 1 + NPH);
      end
    end
  end

  assign f0  = filt[0];
  assign bub = (filt != ph);

endmodule

// File: rtl/tdc_decoder_acc.sv
// TDC back-end: sample capture, decode, modulo phase difference and windowed averaging.
module tdc_decoder_acc
  import tdc_decoder_acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  counter_in,
  input  logic [NPH-1:0]    phase_in,
  input  logic [SEL_W-1:0]  avg_sel,
  output logic [WORD_W-1:0] tdc_word,
  output logic              tdc_valid,
  output logic              bubble_flag
);

  tdc_sample_t       s1_q;
  logic              s1_vld;
  logic              f0_c;
  logic              bub_c;
  logic [FRAC_W-1:0] idx_c;
  logic [CNT_W-1:0]  cnt_aux_c;
  logic [CNT_W-1:0]  cnt_diff_c;
  logic [WORD_W-1:0] raw_c;

  logic [CNT_W-1:0]  cnt_last;
  logic [FRAC_W-1:0] idx_last;
  logic [WORD_W-1:0] raw_q;
  logic              bub_q;
  logic              raw_vld;
  logic              primed;

  logic [ACC_W-1:0]  acc;
  logic              bub_win;
  logic [WIN_W-1:0]  win_cnt;
  logic [SEL_W-1:0]  avg_lat;
  logic              first_c;
  logic              last_c;
  logic [SEL_W-1:0]  sel_c;
  logic [ACC_W-1:0]  sum_c;
  logic              bor_c;

  tdc_decoder_acc_therm_decode #(
    .NPH   (NPH),
    .IDX_W (FRAC_W)
  ) u_decode (
    .ph  (s1_q.ph),
    .f0  (f0_c),
    .idx (idx_c),
    .bub (bub_c)
  );

  // Phase difference against the previous sample, all modulo word width.
  always_comb begin
    cnt_aux_c  = s1_q.cnt - CNT_W'(f0_c);
    cnt_diff_c = cnt_last - cnt_aux_c;
    raw_c      = {cnt_diff_c, FRAC_W'(0)} + WORD_W'(idx_c) - WORD_W'(idx_last);
  end

  // Window bookkeeping: first sample latches avg_sel and seeds the sum.
  always_comb begin
    first_c = (win_cnt == '0);
    sel_c   = first_c ? clamp_sel(avg_sel) : avg_lat;
    sum_c   = first_c ? ACC_W'(raw_q) : acc + ACC_W'(raw_q);
    bor_c   = first_c ? bub_q : (bub_win | bub_q);
    last_c  = (win_cnt == WIN_W'((32'd1 << sel_c) - 32'd1));
  end

  // Input capture stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s1_vld <= 1'b0;
    end else if (en) begin
      s1_q   <= '{cnt: counter_in, ph: phase_in};
      s1_vld <= 1'b1;
    end
  end

  // Reference update and raw word register; the first sample only primes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_last <= '0;
      idx_last <= '0;
      raw_q    <= '0;
      bub_q    <= 1'b0;
      raw_vld  <= 1'b0;
      primed   <= 1'b0;
    end else if (en) begin
      if (s1_vld) begin
        cnt_last <= cnt_aux_c;
        idx_last <= idx_c;
        raw_q    <= raw_c;
        bub_q    <= bub_c;
        raw_vld  <= primed;
        primed   <= 1'b1;
      end else begin
        raw_vld  <= 1'b0;
      end
    end
  end

  // Accumulator and output registers; tdc_valid pulses once per completed window.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      bub_win     <= 1'b0;
      win_cnt     <= '0;
      avg_lat     <= '0;
      tdc_word    <= '0;
      tdc_valid   <= 1'b0;
      bubble_flag <= 1'b0;
    end else begin
      tdc_valid <= 1'b0;
      if (en && raw_vld) begin
        acc     <= sum_c;
        bub_win <= bor_c;
        avg_lat <= sel_c;
        if (last_c) begin
          win_cnt     <= '0;
          tdc_word    <= WORD_W'(sum_c >> sel_c);
          tdc_valid   <= 1'b1;
          bubble_flag <= bor_c;
        end else begin
          win_cnt <= win_cnt + WIN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tdc_decoder_acc.sv
// Self-checking bench for tdc_decoder_acc: directed cases plus randomized stream.
module tb_tdc_decoder_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [6:0]  counter_in = '0;
  logic [15:0] phase_in = '0;
  logic [1:0]  avg_sel = '0;
  logic [11:0] tdc_word;
  logic        tdc_valid;
  logic        bubble_flag;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit m_primed;
  int ref_aux, ref_idx;
  bit p1_v, p2_v;
  int p1_raw, p2_raw;
  bit p1_bub, p2_bub;
  int win_n, win_sel, win_sum;
  bit win_bor;
  bit m_valid;
  int m_word;
  bit m_flag;

  tdc_decoder_acc dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .counter_in  (counter_in),
    .phase_in    (phase_in),
    .avg_sel     (avg_sel),
    .tdc_word    (tdc_word),
    .tdc_valid   (tdc_valid),
    .bubble_flag (bubble_flag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Decode straight from the rules: majority filter, scan edges from the top down.
  function automatic void model_decode(input logic [15:0] ph, output int idx,
                                       output int f0, output bit bub);
    logic [15:0] f;
    int ones;
    for (int i = 0; i < 16; i++) begin
      ones = int'(ph[(i + 15) % 16]) + int'(ph[i]) + int'(ph[(i + 1) % 16]);
      f[i] = (ones >= 2);
    end
    bub = (f != ph);
    idx = -1;
    for (int j = 15; j >= 1; j--) begin
      if (idx < 0 && f[j-1] != f[j]) idx = f[j-1] ? (j - 1) : (j + 15);
    end
    if (idx < 0) idx = f[0] ? 15 : 31;
    f0 = int'(f[0]);
  endfunction

  task automatic model_reset();
    m_primed = 0; ref_aux = 0; ref_idx = 0;
    p1_v = 0; p2_v = 0; p1_raw = 0; p2_raw = 0; p1_bub = 0; p2_bub = 0;
    win_n = 0; win_sel = 0; win_sum = 0; win_bor = 0;
    m_valid = 0; m_word = 0; m_flag = 0;
  endtask

  // A raw word reaches the averager on the enabled edge two samples after its own.
  task automatic model_push(input int c, input logic [15:0] p, input int s);
    int idx, f0, aux;
    bit bub;
    m_valid = 0;
    if (p2_v) begin
      if (win_n == 0) begin
        win_sel = (s > 3) ? 3 : s;
        win_sum = p2_raw;
        win_bor = p2_bub;
      end else begin
        win_sum = win_sum + p2_raw;
        win_bor = win_bor | p2_bub;
      end
      win_n++;
      if (win_n == (1 << win_sel)) begin
        m_valid = 1;
        m_word  = (win_sum >> win_sel) & 4095;
        m_flag  = win_bor;
        win_n   = 0;
      end
    end
    p2_v = p1_v; p2_raw = p1_raw; p2_bub = p1_bub;
    model_decode(p, idx, f0, bub);
    aux = (c - f0) & 127;
    if (m_primed) begin
      p1_v   = 1;
      p1_raw = ((ref_aux - aux) * 32 + idx - ref_idx) & 4095;
      p1_bub = bub;
    end else begin
      p1_v = 0;
    end
    m_primed = 1;
    ref_aux  = aux;
    ref_idx  = idx;
  endtask

  // One clock: drive on negedge, advance model, check #1 after the rising edge.
  task automatic step(input bit r, input bit e, input int c, input logic [15:0] p, input int s);
    @(negedge clk);
    rst        = r;
    en         = e;
    counter_in = 7'(c);
    phase_in   = p;
    avg_sel    = 2'(s);
    if (r) model_reset();
    else if (e) model_push(c & 127, p, s);
    else m_valid = 0;
    @(posedge clk);
    #1;
    check_eq("valid", 32'(tdc_valid), 32'(m_valid));
    check_eq("word", 32'(tdc_word), 32'(m_word));
    if (m_valid) check_eq("flag", 32'(bubble_flag), 32'(m_flag));
  endtask

  initial begin
    int cnt, len, rot, b, sel;
    logic [15:0] base, p;
    logic [31:0] two;

    model_reset();
    step(1, 0, 0, 16'h0, 0);
    step(1, 0, 0, 16'h0, 0);
    check_eq("rst_word", 32'(tdc_word), 32'h0);
    check_eq("rst_valid", 32'(tdc_valid), 32'h0);
    check_eq("rst_flag", 32'(bubble_flag), 32'h0);

    // Basic difference
    step(0, 1, 10, 16'h00FF, 0);
    step(0, 1, 8, 16'hFF00, 0);
    step(0, 1, 8, 16'hFF00, 0);
    check_eq("basic_novalid", 32'(tdc_valid), 32'h0);
    step(0, 1, 8, 16'hFF00, 0);
    check_eq("basic_valid", 32'(tdc_valid), 32'h1);
    check_eq("basic_word", 32'(tdc_word), 32'h030);

    // Bubble correction
    step(1, 0, 0, 16'h0, 0);
    step(0, 1, 20, 16'h00FF, 0);
    step(0, 1, 20, 16'h00F7, 0);
    step(0, 1, 20, 16'h00FF, 0);
    step(0, 1, 20, 16'h00FF, 0);
    check_eq("bub_word", 32'(tdc_word), 32'h0);
    check_eq("bub_flag", 32'(bubble_flag), 32'h1);
    step(0, 1, 20, 16'h00FF, 0);
    check_eq("bub_clear", 32'(bubble_flag), 32'h0);

    // Counter wrap
    step(1, 0, 0, 16'h0, 0);
    step(0, 1, 0, 16'hFF00, 0);
    step(0, 1, 127, 16'hFF00, 0);
    step(0, 1, 127, 16'hFF00, 0);
    step(0, 1, 127, 16'hFF00, 0);
    check_eq("wrap_word", 32'(tdc_word), 32'h020);

    // No-edge fallbacks
    step(1, 0, 0, 16'h0, 0);
    step(0, 1, 50, 16'h0000, 0);
    step(0, 1, 49, 16'hFFFF, 0);
    step(0, 1, 49, 16'hFFFF, 0);
    step(0, 1, 49, 16'hFFFF, 0);
    check_eq("noedge_word", 32'(tdc_word), 32'h030);

    // Averaging over four words 40,44,48,52; avg_sel drops mid-window
    step(1, 0, 0, 16'h0, 2);
    step(0, 1, 101, 16'h0003, 2);
    step(0, 1, 100, 16'h03FF, 2);
    step(0, 1, 98, 16'hFFC0, 2);
    step(0, 1, 97, 16'h003F, 2);
    step(0, 1, 95, 16'hFC00, 0);
    step(0, 1, 95, 16'hFC00, 0);
    check_eq("avg_midwin", 32'(tdc_valid), 32'h0);
    step(0, 1, 95, 16'hFC00, 0);
    check_eq("avg_valid", 32'(tdc_valid), 32'h1);
    check_eq("avg_word", 32'(tdc_word), 32'd46);
    step(0, 1, 95, 16'hFC00, 0);
    check_eq("avg_next", 32'(tdc_valid), 32'h1);

    // Enable gap, then reset mid-window
    step(1, 0, 0, 16'h0, 0);
    step(0, 1, 60, 16'h00FF, 0);
    step(0, 1, 59, 16'h00FF, 0);
    step(0, 1, 58, 16'h00FF, 0);
    step(0, 1, 57, 16'h00FF, 0);
    check_eq("gap_pre", 32'(tdc_word), 32'h020);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 3, 16'hAAAA, 0);
      check_eq("gap_valid", 32'(tdc_valid), 32'h0);
      check_eq("gap_hold", 32'(tdc_word), 32'h020);
    end
    step(0, 1, 56, 16'h00FF, 0);
    check_eq("gap_resume", 32'(tdc_valid), 32'h1);
    step(0, 1, 55, 16'h00FF, 1);
    step(1, 1, 54, 16'h00FF, 1);
    check_eq("mrst_word", 32'(tdc_word), 32'h0);
    check_eq("mrst_valid", 32'(tdc_valid), 32'h0);
    check_eq("mrst_flag", 32'(bubble_flag), 32'h0);
    step(0, 1, 30, 16'h0FF0, 1);
    step(0, 1, 29, 16'h0FF0, 1);
    check_eq("mrst_prime", 32'(tdc_valid), 32'h0);
    for (int k = 0; k < 4; k++) step(0, 1, 28 - k, 16'h1FE0, 1);

    // Randomized stream
    cnt = 64;
    sel = 0;
    for (int k = 0; k < 600; k++) begin
      len = int'($urandom_range(0, 16));
      base = (len == 16) ? 16'hFFFF : 16'((32'd1 << len) - 32'd1);
      rot = int'($urandom_range(0, 15));
      two = {base, base} >> rot;
      p = two[15:0];
      if ($urandom_range(0, 3) == 0) begin
        b = int'($urandom_range(0, 15));
        p[b] = ~p[b];
      end
      if ($urandom_range(0, 9) == 0) p = 16'($urandom);
      cnt = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 127))
                                         : (cnt - int'($urandom_range(0, 3))) & 127;
      if ($urandom_range(0, 15) == 0) sel = int'($urandom_range(0, 3));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), cnt, p, sel);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
